issue_scoreboard: RTL



---
 rtl/sb_pkg.sv | 60 ++++++
 rtl/reg_pending_bank.sv | 78 +++++++
 rtl/issue_scoreboard.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/sb_pkg.sv
// ----------------------------------------------------------------------------
// sb_pkg
// Shared definitions for the issue scoreboard:
//   - RISC-V major opcode constants
//   - sb_state_t   : drain sequencer states (RUN, DRAIN, DONE)
//   - inst_use_t   : which register fields an instruction reads/writes
//   - decode_use() : opcode -> inst_use_t
// ----------------------------------------------------------------------------
package sb_pkg;

    localparam int IDX_W = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } sb_state_t;

    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
        logic uses_rd;
    } inst_use_t;

    function automatic inst_use_t decode_use(input logic [6:0] opcode);
        inst_use_t u;
        u = '0;
        case (opcode)
            OPC_OP: begin
                u.uses_rs1 = 1'b1;
                u.uses_rs2 = 1'b1;
                u.uses_rd  = 1'b1;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                u.uses_rs1 = 1'b1;
                u.uses_rd  = 1'b1;
            end
            OPC_STORE, OPC_BRANCH: begin
                u.uses_rs1 = 1'b1;
                u.uses_rs2 = 1'b1;
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                u.uses_rd  = 1'b1;
            end
            default: u = '0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/reg_pending_bank.sv
// ----------------------------------------------------------------------------
// reg_pending_bank
// One small up/down counter per architectural register recording how many
// writes to that register are still in flight. Register 0 has no storage and
// always reads as zero.
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   flush_i        : clear every counter on the next edge
//   inc_en_i/idx   : one issued write (caller guarantees counter not full)
//   dec_en_i/idx   : one retired write (ignored when counter already zero)
//   cnt_o          : per-register count
//   zero_o, full_o : per-register empty / saturated flags
//   all_zero_o     : no writes outstanding anywhere
// ----------------------------------------------------------------------------
module reg_pending_bank #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2,
    parameter int IDX_W    = 5
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush_i,
    input  logic                               inc_en_i,
    input  logic [IDX_W-1:0]                   inc_idx_i,
    input  logic                               dec_en_i,
    input  logic [IDX_W-1:0]                   dec_idx_i,
    output logic [NUM_REGS-1:0][CNT_W-1:0]     cnt_o,
    output logic [NUM_REGS-1:0]                zero_o,
    output logic [NUM_REGS-1:0]                full_o,
    output logic                               all_zero_o
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == 0) begin : g_x0
                // x0 is hardwired: never pending, never saturated.
                assign cnt_o[gi]  = '0;
                assign zero_o[gi] = 1'b1;
                assign full_o[gi] = 1'b0;
            end else begin : g_cnt
                logic [CNT_W-1:0] cnt_q;
                logic [CNT_W-1:0] cnt_d;
                logic             inc_hit;
                logic             dec_hit;

                assign inc_hit = inc_en_i && (inc_idx_i == IDX_W'(gi));
                // Decrement of an idle register is dropped so it cannot wrap.
                assign dec_hit = dec_en_i && (dec_idx_i == IDX_W'(gi)) && (cnt_q != '0);

                always_comb begin
                    cnt_d = cnt_q;
                    if (inc_hit && !dec_hit) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (dec_hit && !inc_hit) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end

                always_ff @(posedge clk) begin
                    if (reset || flush_i) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                assign cnt_o[gi]  = cnt_q;
                assign zero_o[gi] = (cnt_q == '0);
                assign full_o[gi] = (cnt_q == '1);
            end
        end
    endgenerate

    assign all_zero_o = &zero_o;

endmodule

// File: rtl/issue_scoreboard.sv
// ----------------------------------------------------------------------------
// issue_scoreboard
// Issue gate between decode and execute. Tracks in-flight register writes,
// stalls decode on RAW hazards (source still pending) and on WAW saturation
// (destination counter full), sequences pipeline drains and handles flush.
//
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   dec_valid/opcode/rd/rs1/rs2     : decoded instruction
//   dec_stall                       : hold instruction in decode
//   iss_valid                       : instruction presented to execute
//   iss_stall                       : execute cannot accept this cycle
//   wb_valid, wb_rd                 : one register write retired
//   flush                           : drop all tracking, return to RUN
//   drain_req                       : level request to empty the pipeline
//   drained                         : pipeline empty, issue held
//   hazard_cycles, drain_cycles     : perf counters (ISSUE_SB_PERF_EN only)
//
// Build option: define ISSUE_SB_PERF_EN to add the two perf counter outputs.
// ----------------------------------------------------------------------------
module issue_scoreboard
    import sb_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dec_valid,
    input  logic [6:0]  dec_opcode,
    input  logic [4:0]  dec_rd,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    output logic        dec_stall,
    output logic        iss_valid,
    input  logic        iss_stall,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        flush,
    input  logic        drain_req,
    output logic        drained
`ifdef ISSUE_SB_PERF_EN
    ,
    output logic [31:0] hazard_cycles,
    output logic [31:0] drain_cycles
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    inst_use_t                         use_w;
    logic                              hazard;
    logic                              run_ok;
    logic                              iss_fire;
    logic                              inc_en;
    logic                              dec_en;
    logic [NUM_REGS-1:0][CNT_W-1:0]    cnt;
    logic [NUM_REGS-1:0]               zero;
    logic [NUM_REGS-1:0]               full;
    logic                              all_zero;
    logic                              last_retire;
    logic                              drain_done;

    sb_state_t                         state_q;
    logic                              drained_q;

    // ------------------------------------------------------------------
    // Hazard detection on registered counts only (no writeback bypass).
    // x0 never reports pending since its counter is hardwired to zero.
    // ------------------------------------------------------------------
    assign use_w  = decode_use(dec_opcode);
    assign hazard = (use_w.uses_rs1 && !zero[dec_rs1])
                 || (use_w.uses_rs2 && !zero[dec_rs2])
                 || (use_w.uses_rd  &&  full[dec_rd]);

    // Issue is also blocked in the cycle drain_req rises and in a flush cycle.
    assign run_ok    = (state_q == RUN) && !drain_req && !flush;
    assign iss_valid = dec_valid && !hazard && run_ok;
    assign dec_stall = iss_stall || hazard || !run_ok;
    assign iss_fire  = iss_valid && !iss_stall;

    assign inc_en = iss_fire && use_w.uses_rd && (dec_rd != '0);
    assign dec_en = wb_valid && !flush;

    reg_pending_bank #(
        .NUM_REGS (NUM_REGS),
        .CNT_W    (CNT_W),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (flush),
        .inc_en_i   (inc_en),
        .inc_idx_i  (dec_rd),
        .dec_en_i   (dec_en),
        .dec_idx_i  (wb_rd),
        .cnt_o      (cnt),
        .zero_o     (zero),
        .full_o     (full),
        .all_zero_o (all_zero)
    );

    // The last outstanding write retires this cycle: exactly one register is
    // pending, it holds a single write, and writeback names it. Nothing can
    // issue while draining, so the counters are guaranteed empty next cycle
    // and DONE can be entered together with the final retirement.
    assign last_retire = wb_valid && (wb_rd != '0)
                      && (cnt[wb_rd] == CNT_ONE)
                      && (~zero == (NUM_REGS'(1) << wb_rd));
    assign drain_done  = all_zero || last_retire;

    // ------------------------------------------------------------------
    // Drain sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q   <= RUN;
            drained_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (drain_req) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!drain_req) begin
                        state_q <= RUN;
                    end else if (drain_done) begin
                        state_q   <= DONE;
                        drained_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (!drain_req) begin
                        state_q   <= RUN;
                        drained_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= RUN;
                    drained_q <= 1'b0;
                end
            endcase
        end
    end

    assign drained = drained_q;

`ifdef ISSUE_SB_PERF_EN
    // Free-running, wrapping counters; flush deliberately leaves them alone.
    logic [31:0] hazard_cycles_q;
    logic [31:0] drain_cycles_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hazard_cycles_q <= '0;
            drain_cycles_q  <= '0;
        end else begin
            if (dec_valid && hazard && (state_q == RUN)) begin
                hazard_cycles_q <= hazard_cycles_q + 32'd1;
            end
            if (state_q == DRAIN) begin
                drain_cycles_q <= drain_cycles_q + 32'd1;
            end
        end
    end

    assign hazard_cycles = hazard_cycles_q;
    assign drain_cycles  = drain_cycles_q;
`endif

endmodule
